hazard_stall_ctrl: RTL

- Pipeline control unit for the 5-stage core.
- Decides each cycle whether the IF/ID register loads, holds (stall) or clears (flush).
- Also gates PC writes and inserts bubbles into ID/EX.
- Tracks multi-cycle HI/LO (mult/div) occupancy with an internal countdown, and keeps saturating stall and flush event counters for performance debug.

---
 rtl/hazard_stall_ctrl_pkg.sv | 13 +
 rtl/hazard_stall_ctrl_muldiv_busy_tracker.sv | 31 +++
 rtl/hazard_stall_ctrl.sv | 66 ++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// hazard_stall_ctrl_pkg: shared pipeline constants, muldiv state type and hazard match helper
package hazard_stall_ctrl_pkg;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;
  localparam int MD_LATENCY = 32;
  localparam int MD_CNT_W = 8;
  typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;
  function automatic logic src_match(input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                                     input logic use_rs, input logic use_rt,
                                     input logic [REG_W-1:0] rd);
    return (rd != REG_ZERO) && ((use_rs && rs == rd) || (use_rt && rt == rd));
  endfunction
endpackage

// File: rtl/hazard_stall_ctrl_muldiv_busy_tracker.sv
// muldiv_busy_tracker: HI/LO occupancy countdown and busy flag for multi-cycle mult/div
module muldiv_busy_tracker
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MULDIV_LATENCY = MD_LATENCY
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_md_start,
  output logic o_md_busy
);
  localparam logic [MD_CNT_W-1:0] RELOAD = MD_CNT_W'(MULDIV_LATENCY - 1);
  md_state_t r_state, w_state_nxt;
  logic [MD_CNT_W-1:0] r_md_cnt, w_md_cnt_nxt;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= MD_IDLE;
      r_md_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
    end
  end
  // a new start always restarts the full latency, even mid-count
  always_comb begin
    w_md_cnt_nxt = i_md_start ? RELOAD : (r_md_cnt != '0 ? r_md_cnt - 1'b1 : r_md_cnt);
    w_state_nxt  = i_md_start ? MD_BUSY
                 : (r_state == MD_BUSY && r_md_cnt == MD_CNT_W'(1)) ? MD_IDLE : r_state;
  end
  assign o_md_busy = (r_md_cnt != '0);
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: stall/flush/bubble control for the 5-stage pipeline with perf counters
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MULDIV_LATENCY = MD_LATENCY,
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [REG_W-1:0] i_ifid_rs,
  input  logic [REG_W-1:0] i_ifid_rt,
  input  logic             i_ifid_uses_rs,
  input  logic             i_ifid_uses_rt,
  input  logic             i_ifid_uses_hilo,
  input  logic             i_id_branch,
  input  logic             i_id_branch_taken,
  input  logic             i_id_jump,
  input  logic             i_idex_mem_read,
  input  logic             i_idex_reg_write,
  input  logic [REG_W-1:0] i_idex_rd,
  input  logic             i_exmem_mem_read,
  input  logic [REG_W-1:0] i_exmem_rd,
  input  logic             i_md_start,
  output logic             o_pc_write_enable,
  output logic             o_ifid_write_enable,
  output logic             o_ifid_flush,
  output logic             o_idex_bubble,
  output logic             o_md_busy,
  output logic [CNT_W-1:0] o_stall_count,
  output logic [CNT_W-1:0] o_flush_count
);
  logic w_md_busy, w_ex_match, w_mem_match, w_stall, w_flush;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  muldiv_busy_tracker #(.MULDIV_LATENCY(MULDIV_LATENCY)) u_md (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_md_start (i_md_start),
    .o_md_busy  (w_md_busy)
  );
  // stall outranks flush: a branch waiting on operands has no valid outcome yet
  always_comb begin
    w_ex_match  = src_match(i_ifid_rs, i_ifid_rt, i_ifid_uses_rs, i_ifid_uses_rt, i_idex_rd);
    w_mem_match = src_match(i_ifid_rs, i_ifid_rt, i_ifid_uses_rs, i_ifid_uses_rt, i_exmem_rd);
    w_stall     = (i_idex_mem_read && w_ex_match)
                || (i_id_branch && i_idex_reg_write && w_ex_match)
                || (i_id_branch && i_exmem_mem_read && w_mem_match)
                || (i_ifid_uses_hilo && (w_md_busy || i_md_start));
    w_flush     = !w_stall && (i_id_jump || (i_id_branch && i_id_branch_taken));
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end
  assign o_pc_write_enable   = !w_stall;
  assign o_ifid_write_enable = !w_stall;
  assign o_idex_bubble       = w_stall;
  assign o_ifid_flush        = w_flush;
  assign o_md_busy           = w_md_busy;
  assign o_stall_count       = r_stall_cnt;
  assign o_flush_count       = r_flush_cnt;
endmodule
